// File: rtl/fpu_pkg.sv
// Shared FP rounding definitions: rounding-mode codes and the
// round-increment decision used by the multiplier and adder paths.
package fpu_pkg;

  localparam logic [1:0] RM_RNE = 2'b00;
  localparam logic [1:0] RM_RTZ = 2'b01;
  localparam logic [1:0] RM_RUP = 2'b10;
  localparam logic [1:0] RM_RDN = 2'b11;

  function automatic logic round_inc(
    input logic       g,
    input logic       r,
    input logic       s,
    input logic       lsb,
    input logic       sign,
    input logic [1:0] rmode
  );
    logic inc;
    logic lost;
    lost = g | r | s;
    inc  = 1'b0;
    unique case (rmode)
      RM_RNE: inc = g & (r | s | lsb);
      RM_RTZ: inc = 1'b0;
      RM_RUP: inc = ~sign & lost;
      RM_RDN: inc = sign & lost;
      default: inc = 1'b0;
    endcase
    return inc;
  endfunction

endpackage

// File: rtl/grs_round_pipe_if.sv
// Upstream/downstream bundle of the rounding pipe.
// master drives the operands, slave is the pipe itself.
interface grs_round_pipe_if #(
  parameter int MAN_W  = 23,
  parameter int PROD_W = 48
);

  logic              in_valid;
  logic [PROD_W-1:0] product;
  logic              sign;
  logic [1:0]        rmode;
  logic              out_valid;
  logic [MAN_W-1:0]  man_out;
  logic [1:0]        exp_adj;
  logic              inexact;

  modport master (
    output in_valid, product, sign, rmode,
    input  out_valid, man_out, exp_adj, inexact
  );

  modport slave (
    input  in_valid, product, sign, rmode,
    output out_valid, man_out, exp_adj, inexact
  );

endinterface

// File: rtl/grs_round_pipe_extract.sv
// Guard/round/sticky extraction from a 2.(PROD_W-2) significand,
// normalised on the product MSB.
module grs_extract #(
  parameter int MAN_W  = 23,
  parameter int PROD_W = 48
) (
  input  logic [PROD_W-1:0] product_i,
  output logic [MAN_W-1:0]  mant_o,
  output logic              g_o,
  output logic              r_o,
  output logic              s_o,
  output logic              m_o
);

  logic [PROD_W-2:0] norm;

  // m=0 is handled by a 1-bit left shift so both cases share one slice
  assign m_o    = product_i[PROD_W-1];
  assign norm   = m_o ? product_i[PROD_W-2:0]
                      : {product_i[PROD_W-3:0], 1'b0};
  assign mant_o = norm[PROD_W-2 -: MAN_W];
  assign g_o    = norm[PROD_W-2-MAN_W];
  assign r_o    = norm[PROD_W-3-MAN_W];
  assign s_o    = |norm[PROD_W-4-MAN_W:0];

endmodule

// File: rtl/grs_round_pipe.sv
// 3-stage GRS extraction and IEEE-754 rounding pipe with global HOLD,
// between the multiplier array and the exponent/packing stage.
module grs_round_pipe
  import fpu_pkg::*;
#(
  parameter int MAN_W  = 23,
  parameter int PROD_W = 48
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              HOLD,
  grs_round_pipe_if.slave   bus
);

  if (PROD_W < MAN_W + 5) begin : g_bad_width
    $error("grs_round_pipe: PROD_W must be >= MAN_W+5");
  end

  logic              v1_q, v2_q, v3_q;
  logic [PROD_W-1:0] prod1_q;
  logic              sign1_q, sign2_q;
  logic [1:0]        rm1_q, rm2_q;

  logic [MAN_W-1:0]  mant2_d, mant2_q;
  logic              g2_d, r2_d, s2_d, m2_d;
  logic              g2_q, r2_q, s2_q, m2_q;

  logic              inc3;
  logic              c3;
  logic [MAN_W-1:0]  man3_d, man3_q;
  logic [1:0]        adj3_d, adj3_q;
  logic              inx3_d, inx3_q;

  grs_extract #(
    .MAN_W  (MAN_W),
    .PROD_W (PROD_W)
  ) u_extract (
    .product_i (prod1_q),
    .mant_o    (mant2_d),
    .g_o       (g2_d),
    .r_o       (r2_d),
    .s_o       (s2_d),
    .m_o       (m2_d)
  );

  // a carry out of the mantissa leaves man_out all zeros
  always_comb begin
    inc3           = round_inc(g2_q, r2_q, s2_q, mant2_q[0],
                               sign2_q, rm2_q);
    {c3, man3_d}   = {1'b0, mant2_q} + {{MAN_W{1'b0}}, inc3};
    adj3_d         = {1'b0, m2_q} + {1'b0, c3};
    inx3_d         = g2_q | r2_q | s2_q;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      v1_q    <= 1'b0;
      prod1_q <= '0;
      sign1_q <= 1'b0;
      rm1_q   <= '0;
    end else if (!HOLD) begin
      v1_q    <= bus.in_valid;
      prod1_q <= bus.product;
      sign1_q <= bus.sign;
      rm1_q   <= bus.rmode;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      v2_q    <= 1'b0;
      mant2_q <= '0;
      g2_q    <= 1'b0;
      r2_q    <= 1'b0;
      s2_q    <= 1'b0;
      m2_q    <= 1'b0;
      sign2_q <= 1'b0;
      rm2_q   <= '0;
    end else if (!HOLD) begin
      v2_q    <= v1_q;
      mant2_q <= mant2_d;
      g2_q    <= g2_d;
      r2_q    <= r2_d;
      s2_q    <= s2_d;
      m2_q    <= m2_d;
      sign2_q <= sign1_q;
      rm2_q   <= rm1_q;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      v3_q   <= 1'b0;
      man3_q <= '0;
      adj3_q <= '0;
      inx3_q <= 1'b0;
    end else if (!HOLD) begin
      v3_q   <= v2_q;
      man3_q <= man3_d;
      adj3_q <= adj3_d;
      inx3_q <= inx3_d;
    end
  end

  assign bus.out_valid = v3_q;
  assign bus.man_out   = man3_q;
  assign bus.exp_adj   = adj3_q;
  assign bus.inexact   = inx3_q;

endmodule

// File: tb/tb_grs_round_pipe.sv
// Self-checking bench for grs_round_pipe: directed corner cases,
// HOLD/reset behaviour and random traffic against an arithmetic model.
module tb_grs_round_pipe;

  localparam int MAN_W  = 23;
  localparam int PROD_W = 48;

  typedef struct {
    logic        v;
    logic [22:0] man;
    logic [1:0]  adj;
    logic        inx;
  } exp_t;

  logic CLK = 1'b0;
  logic RST;
  logic HOLD;

  int   n_assert = 0;
  int   n_fail   = 0;
  exp_t pipe_q[$];
  exp_t cur;

  always #5 CLK = ~CLK;

  grs_round_pipe_if #(.MAN_W(MAN_W), .PROD_W(PROD_W)) bus ();

  grs_round_pipe #(
    .MAN_W  (MAN_W),
    .PROD_W (PROD_W)
  ) dut (
    .CLK  (CLK),
    .RST  (RST),
    .HOLD (HOLD),
    .bus  (bus)
  );

  // Rounds the exact value p / 2^46 to MAN_W fraction bits
  function automatic exp_t ref_round(logic [47:0] p, logic s,
                                     logic [1:0] rm);
    exp_t        e;
    logic [63:0] pp, q, rem, half;
    int          sh;
    logic        inc;
    pp   = {16'd0, p};
    sh   = p[47] ? 24 : 23;
    q    = pp >> sh;
    rem  = pp - (q << sh);
    half = 64'd1 << (sh - 1);
    case (rm)
      2'b00:   inc = (rem > half) || (rem == half && q[0]);
      2'b01:   inc = 1'b0;
      2'b10:   inc = (rem != 0) && !s;
      default: inc = (rem != 0) && s;
    endcase
    q     = q + {63'd0, inc};
    e.v   = 1'b1;
    e.inx = (rem != 0);
    if (q >= (64'd1 << 24)) begin
      e.man = '0;
      e.adj = p[47] ? 2'd2 : 2'd1;
    end else begin
      e.man = q[22:0];
      e.adj = p[47] ? 2'd1 : 2'd0;
    end
    return e;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    exp_t z;
    z = '{v: 1'b0, man: '0, adj: '0, inx: 1'b0};
    pipe_q.delete();
    pipe_q.push_back(z);
    pipe_q.push_back(z);
    cur = z;
  endtask

  task automatic step(logic v, logic [47:0] p, logic s, logic [1:0] rm,
                      logic h, string tag);
    exp_t e;
    bus.in_valid = v;
    bus.product  = p;
    bus.sign     = s;
    bus.rmode    = rm;
    HOLD         = h;
    if (v && !h)
      chk({tag, "_normalised"}, {31'd0, p[47] | p[46]}, 32'd1);
    @(posedge CLK);
    #1;
    if (!h) begin
      e   = ref_round(p, s, rm);
      e.v = v;
      pipe_q.push_back(e);
      cur = pipe_q.pop_front();
    end
    chk({tag, "_vld"}, {31'd0, bus.out_valid}, {31'd0, cur.v});
    if (cur.v) begin
      chk({tag, "_man"}, {9'd0, bus.man_out}, {9'd0, cur.man});
      chk({tag, "_adj"}, {30'd0, bus.exp_adj}, {30'd0, cur.adj});
      chk({tag, "_inx"}, {31'd0, bus.inexact}, {31'd0, cur.inx});
    end
  endtask

  task automatic directed(string tag, logic [47:0] p, logic s,
                          logic [1:0] rm, logic [22:0] em,
                          logic [1:0] ea, logic ei);
    step(1'b1, p, s, rm, 1'b0, tag);
    step(1'b0, 48'h0, 1'b0, 2'b00, 1'b0, tag);
    step(1'b0, 48'h0, 1'b0, 2'b00, 1'b0, tag);
    chk({tag, "_dir_vld"}, {31'd0, bus.out_valid}, 32'd1);
    chk({tag, "_dir_man"}, {9'd0, bus.man_out}, {9'd0, em});
    chk({tag, "_dir_adj"}, {30'd0, bus.exp_adj}, {30'd0, ea});
    chk({tag, "_dir_inx"}, {31'd0, bus.inexact}, {31'd0, ei});
  endtask

  function automatic logic [47:0] rnd_prod();
    logic [63:0] r;
    r = {$urandom, $urandom};
    if (r[47:46] == 2'b00) r[46] = 1'b1;
    return r[47:0];
  endfunction

  initial begin
    RST          = 1'b1;
    HOLD         = 1'b0;
    bus.in_valid = 1'b0;
    bus.product  = '0;
    bus.sign     = 1'b0;
    bus.rmode    = 2'b00;
    #1;
    chk("rst_vld", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_man", {9'd0, bus.man_out}, 32'd0);
    chk("rst_adj", {30'd0, bus.exp_adj}, 32'd0);
    chk("rst_inx", {31'd0, bus.inexact}, 32'd0);
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    model_reset();

    directed("tie_even", 48'h800000_800000, 1'b0, 2'b00,
             23'h000000, 2'd1, 1'b1);
    directed("tie_odd", 48'h800001_800000, 1'b0, 2'b00,
             23'h000002, 2'd1, 1'b1);
    directed("carry_rne", 48'hFFFFFF_FFFFFF, 1'b0, 2'b00,
             23'h000000, 2'd2, 1'b1);
    directed("carry_rtz", 48'hFFFFFF_FFFFFF, 1'b0, 2'b01,
             23'h7FFFFF, 2'd1, 1'b1);
    directed("s_rup_pos", 48'h400000_000001, 1'b0, 2'b10,
             23'h000001, 2'd0, 1'b1);
    directed("s_rdn_pos", 48'h400000_000001, 1'b0, 2'b11,
             23'h000000, 2'd0, 1'b1);
    directed("s_rdn_neg", 48'h400000_000001, 1'b1, 2'b11,
             23'h000001, 2'd0, 1'b1);

    for (int i = 0; i < 8; i++)
      step(1'b1, rnd_prod(), 1'($urandom), 2'($urandom),
           (i == 3 || i == 4), "hold_stream");
    repeat (3) step(1'b0, rnd_prod(), 1'b0, 2'b00, 1'b0, "hold_drain");

    repeat (3) step(1'b1, rnd_prod(), 1'($urandom), 2'($urandom),
                    1'b0, "rst_fill");
    RST = 1'b1;
    #1;
    chk("rst_async_vld", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_async_man", {9'd0, bus.man_out}, 32'd0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    model_reset();
    repeat (4) step(1'b0, rnd_prod(), 1'b0, 2'b00, 1'b0, "rst_after");
    directed("post_rst", 48'h800001_800000, 1'b0, 2'b00,
             23'h000002, 2'd1, 1'b1);

    for (int i = 0; i < 300; i++)
      step(($urandom_range(0, 3) != 0), rnd_prod(), 1'($urandom),
           2'($urandom), ($urandom_range(0, 9) == 0), "rand");
    repeat (3) step(1'b0, rnd_prod(), 1'b0, 2'b00, 1'b0, "drain");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/grs_round_pipe.md
Name: grs_round_pipe

Overview:
- Parametrised successor to the multiplier's fixed 23-bit sticky-bit block.
- Takes the raw significand product and extracts the guard, round and sticky bits, with normalisation selected by the product MSB.
- Applies one of four IEEE-754 rounding modes and emits the rounded mantissa, the exponent adjustment and an inexact flag.
- 3-stage valid pipeline with a global HOLD stall; sits between the multiplier array and the exponent/packing stage.

Parameters:
- MAN_W, 23: stored mantissa width (fraction bits, hidden bit excluded).
- PROD_W, 48: product width. Format is 2 integer bits plus PROD_W-2 fraction bits. Requires PROD_W >= MAN_W+5, checked by an elaboration-time assertion.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous reset, active-high.
- HOLD  in  1  stall; when 1, every pipeline register keeps its value.
- in_valid  in  1  input qualifier.
- product  in  PROD_W  unsigned significand product.
- sign  in  1  result sign.
- rmode  in  2  rounding mode: 00 RNE, 01 RTZ, 10 RUP (toward +inf), 11 RDN (toward -inf).
- out_valid  out  1  output qualifier.
- man_out  out  MAN_W  rounded mantissa, hidden bit excluded.
- exp_adj  out  2  exponent increment: 0, 1 or 2.
- inexact  out  1  G|R|S, taken before rounding.

Behaviour:
- Reset: all pipeline registers clear asynchronously while RST=1. out_valid=0, man_out=0, exp_adj=0, inexact=0. Any reset mid-operation discards in-flight data; no partial results appear after release.
- Latency: exactly 3 un-held cycles from in_valid sampled to out_valid. Throughput is 1 per cycle.
- HOLD=1: all stages freeze, including the valid bits. Inputs presented that cycle are ignored, and outputs stay stable.
- Bubbles: in_valid=0 advances a bubble. Datapath registers load regardless of valid; only the valid bit gates meaning. Outputs with out_valid=0 are don't-care except after reset.
- Stage 1 registers product, sign, rmode and valid.
- Stage 2 performs GRS extraction. Let m = product[PROD_W-1].
  - m=1: mant = product[PROD_W-2 -: MAN_W], G = the next lower bit, R = the bit below G, S = OR of all remaining lower bits.
  - m=0: the same extraction, shifted down one bit.
  - Registers mant, G, R, S, m, sign, rmode and valid.
- Stage 3 rounding:
  - inc, RNE: G & (R | S | mant[0]).
  - inc, RTZ: 0.
  - inc, RUP: ~sign & (G|R|S).
  - inc, RDN: sign & (G|R|S).
  - {c, man_out} = mant + inc (MAN_W+1-bit add).
  - exp_adj = m + c, 2-bit sum.
  - On carry, man_out is all zeros (1.11..1 + ulp = 10.0..0).
  - inexact = G|R|S.
  - All outputs are registered.
- product < 2^(PROD_W-2) (both top bits 0) is unnormalised: undefined result, flagged by a bench assertion only.

Decomposition:
- fpu_pkg holds:
  - rounding-mode localparams RM_RNE=2'b00, RM_RTZ=2'b01, RM_RUP=2'b10, RM_RDN=2'b11;
  - a shared function round_inc(G, R, S, lsb, sign, rmode).
- One sub-module is natural: grs_extract, the combinational stage-2 slice selection and OR-reduction parametrised on MAN_W/PROD_W, reusable by the adder path.

Test Plan (MAN_W=23, PROD_W=48):
- product=48'h800000_800000, sign=0, RNE (exact tie, even lsb) -> after 3 cycles: man_out=0, exp_adj=1, inexact=1.
- product=48'h800001_800000, RNE (tie, odd lsb) -> man_out=23'h000002, exp_adj=1, inexact=1.
- product=48'hFFFFFF_FFFFFF, RNE -> rounding carry, man_out=0, exp_adj=2, inexact=1. Repeat with RTZ -> man_out=23'h7FFFFF, exp_adj=1.
- product=48'h400000_000001 (m=0, only S=1):
  - RUP with sign=0 -> man_out=1, exp_adj=0, inexact=1;
  - RDN with sign=0 -> man_out=0, inexact=1;
  - RDN with sign=1 -> man_out=1.
- Stream of 6 back-to-back valid inputs with HOLD=1 for 2 cycles mid-stream -> outputs in order, none lost or duplicated, each appearing 3 un-held cycles after entry; outputs stable during HOLD.
- RST pulsed while 3 valid items are in flight -> out_valid=0 immediately (asynchronous) and stays 0 until new input plus 3 cycles.
